// File: rtl/core_check_pkg.sv
// Shared types and defaults for the core result checker.
package core_check_pkg;

  // Checker FSM states; encodings are fixed so they can be probed on hardware.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_CHECK  = 3'd2,
    ST_PASS   = 3'd3,
    ST_FAIL   = 3'd4
  } state_e;

  localparam int DEF_DATA_W        = 32;
  localparam int DEF_NUM_CH        = 1;
  localparam int DEF_STABLE_CYCLES = 4;
  localparam int DEF_CNT_W         = 16;

  // Bits needed to hold values 0..max_val (at least one bit).
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/stable_detect.sv
// One result channel: remembers the previous sample and counts consecutive
// unchanged cycles, saturating at STABLE_CYCLES.
module stable_detect
  import core_check_pkg::*;
#(
  parameter int DATA_W        = DEF_DATA_W,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] sample_i,
  output logic              settled_o
);

  localparam int            CW  = cnt_width(STABLE_CYCLES);
  localparam logic [CW-1:0] SAT = CW'(STABLE_CYCLES);

  logic [DATA_W-1:0] prev_q;
  logic [CW-1:0]     cnt_q;
  logic [CW-1:0]     cnt_d;

  // Next stability count: grows while the sample repeats, drops to zero on change.
  always_comb begin
    // NOTE: every variable driven here gets a default first, so no path leaves it
    // holding its old value and no latch is inferred.
    cnt_d = '0;
    if (sample_i == prev_q) begin
      cnt_d = (cnt_q == SAT) ? SAT : cnt_q + CW'(1);
    end
  end

  // Settled means the count this sample produces reaches the window, so the
  // decision can be taken on the same edge that completes the window.
  assign settled_o = (cnt_d == SAT);

  // Sample history and counter; clear reloads the history on entry to checking.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_ni) begin
      prev_q <= '0;
      cnt_q  <= '0;
    end else if (clear_i) begin
      prev_q <= sample_i;
      cnt_q  <= '0;
    end else if (en_i) begin
      prev_q <= sample_i;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/core_result_checker.sv
// Run-and-check monitor: waits a programmable settle time, waits for every
// result channel to hold steady, then compares against latched expectations
// and reports sticky pass/fail with a mismatch mask and elapsed cycle count.
module core_result_checker
  import core_check_pkg::*;
#(
  parameter int DATA_W        = DEF_DATA_W,
  parameter int NUM_CH        = DEF_NUM_CH,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic [CNT_W-1:0]         settle_i,
  input  logic [CNT_W-1:0]         timeout_i,
  input  logic [NUM_CH*DATA_W-1:0] result_i,
  input  logic [NUM_CH*DATA_W-1:0] expect_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     pass_o,
  output logic                     fail_o,
  output logic                     timeout_o,
  output logic [NUM_CH-1:0]        mismatch_o,
  output logic [NUM_CH*DATA_W-1:0] captured_o,
  output logic [CNT_W-1:0]         cycles_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e                   state_q;
  logic [CNT_W-1:0]         settle_cnt_q;
  logic [CNT_W-1:0]         timeout_q;
  logic [CNT_W-1:0]         check_cnt_q;
  logic [CNT_W-1:0]         check_cnt_d;
  logic [NUM_CH*DATA_W-1:0] expect_q;
  logic [NUM_CH-1:0]        settled;
  logic [NUM_CH-1:0]        differs;
  logic                     can_start;
  logic                     in_check;
  logic                     busy_state;
  logic                     enter_check;
  logic                     all_settled;
  logic                     timeout_hit;

  // Transition conditions shared by the FSM and the channel detectors.
  always_comb begin
    can_start   = (state_q == ST_IDLE) || (state_q == ST_PASS) || (state_q == ST_FAIL);
    in_check    = (state_q == ST_CHECK);
    busy_state  = (state_q == ST_SETTLE) || in_check;
    enter_check = (can_start && start_i && (settle_i == '0))
               || ((state_q == ST_SETTLE) && (settle_cnt_q == CNT_ONE));
    all_settled = &settled;
    check_cnt_d = (check_cnt_q == CNT_MAX) ? CNT_MAX : check_cnt_q + CNT_ONE;
    timeout_hit = in_check && (timeout_q != '0) && (check_cnt_d == timeout_q);
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    stable_detect #(
      .DATA_W       (DATA_W),
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_detect (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .clear_i  (enter_check),
      .en_i     (in_check),
      .sample_i (result_i[k*DATA_W +: DATA_W]),
      .settled_o(settled[k])
    );

    assign differs[k] = (result_i[k*DATA_W +: DATA_W] != expect_q[k*DATA_W +: DATA_W]);
  end

  // Run control FSM with latched run parameters and registered status outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      settle_cnt_q <= '0;
      timeout_q    <= '0;
      check_cnt_q  <= '0;
      expect_q     <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      pass_o       <= 1'b0;
      fail_o       <= 1'b0;
      timeout_o    <= 1'b0;
      mismatch_o   <= '0;
      captured_o   <= '0;
      cycles_o     <= '0;
    end else begin
      done_o <= 1'b0;
      if (busy_state && (cycles_o != CNT_MAX)) begin
        cycles_o <= cycles_o + CNT_ONE;
      end

      case (state_q)
        ST_IDLE, ST_PASS, ST_FAIL: begin
          if (start_i) begin
            settle_cnt_q <= settle_i;
            timeout_q    <= timeout_i;
            expect_q     <= expect_i;
            check_cnt_q  <= '0;
            pass_o       <= 1'b0;
            fail_o       <= 1'b0;
            timeout_o    <= 1'b0;
            mismatch_o   <= '0;
            cycles_o     <= '0;
            busy_o       <= 1'b1;
            state_q      <= (settle_i == '0) ? ST_CHECK : ST_SETTLE;
          end
        end

        ST_SETTLE: begin
          if (settle_cnt_q == CNT_ONE) begin
            check_cnt_q <= '0;
            state_q     <= ST_CHECK;
          end else begin
            settle_cnt_q <= settle_cnt_q - CNT_ONE;
          end
        end

        ST_CHECK: begin
          check_cnt_q <= check_cnt_d;
          // A settled decision on the same edge as the timeout takes priority.
          if (all_settled) begin
            captured_o <= result_i;
            mismatch_o <= differs;
            done_o     <= 1'b1;
            busy_o     <= 1'b0;
            if (differs == '0) begin
              pass_o  <= 1'b1;
              state_q <= ST_PASS;
            end else begin
              fail_o  <= 1'b1;
              state_q <= ST_FAIL;
            end
          end else if (timeout_hit) begin
            captured_o <= result_i;
            mismatch_o <= ~settled | differs;
            timeout_o  <= 1'b1;
            fail_o     <= 1'b1;
            done_o     <= 1'b1;
            busy_o     <= 1'b0;
            state_q    <= ST_FAIL;
          end
        end

        default: begin
          busy_o  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
